// File: rtl/cu_mc.sv
// ---------------------------------------------------------------------------
// cu_mc : multi-cycle control unit for the mycpu datapath.
//
// Decodes the instruction register and drives the datapath, PC and memory/IO
// controls. Instruction fetch and data memory/IO access are handshaked. A
// resumable halt state and an iterating XXL loop state are provided.
//
// Opcode map (opcode = ins_in[IW-1 -: 7]):
//   000_xxxx  ALU register op, fs = opcode[3:0]
//   100_1100  LDI            100_0010  ADI
//   001_0000  LD             010_0000  ST
//   001_0001  IOR            010_0001  IOW
//   110_0000  BRZ            110_0001  BRN
//   111_0000  JMP            111_0001  HAL
//   111_0010  XXL            anything else : NOP
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   ins_in        instruction register, {opcode, ..., dst, srcA, srcB}
//   ins_vld       instruction memory data valid (fetch handshake)
//   dmem_rdy      data memory/IO access complete
//   z_in, n_in    ALU zero / negative flags
//   resume_in     leave the halt state
//   il_out        instruction register load
//   ps_out        PC select: 00 hold, 01 +1, 10 +offset, 11 jump
//   rw_out        register file write
//   rs_out        register selects {0,dst,0,srcA,0,srcB}
//   mm_out        address mux select (1 = register operand)
//   md_out        write-back select: 00 ALU, 01 memory, 10 IO
//   mb_out        B operand = immediate
//   fs_out        ALU function
//   wen_out       memory write enable, active low
//   iom_out       IO space select
//   mreq_out      data memory/IO request
//   halted_out    high while halted
//   state_out     current FSM state (debug)
//
// Handshakes: a fetch completes in the INF cycle where ins_vld is high; a
// data access holds mreq_out and all its controls stable from the first MEM
// cycle until the cycle where dmem_rdy is high, and that cycle is the last.
// ---------------------------------------------------------------------------
module cu_mc #(
    parameter int IW     = 16,
    parameter int RA_W   = 3,
    parameter int XL_MAX = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IW-1:0]           ins_in,
    input  logic                    ins_vld,
    input  logic                    dmem_rdy,
    input  logic                    z_in,
    input  logic                    n_in,
    input  logic                    resume_in,
    output logic                    il_out,
    output logic [1:0]              ps_out,
    output logic                    rw_out,
    output logic [3*(RA_W+1)-1:0]   rs_out,
    output logic                    mm_out,
    output logic [1:0]              md_out,
    output logic                    mb_out,
    output logic [3:0]              fs_out,
    output logic                    wen_out,
    output logic                    iom_out,
    output logic                    mreq_out,
    output logic                    halted_out,
    output logic [2:0]              state_out
);

    localparam int XW = (XL_MAX < 1) ? 1 : $clog2(XL_MAX + 1);
    localparam logic [XW-1:0] XL_MAX_C = XW'(XL_MAX);

    localparam logic [6:0] OP_LDI = 7'b1001100;
    localparam logic [6:0] OP_ADI = 7'b1000010;
    localparam logic [6:0] OP_LD  = 7'b0010000;
    localparam logic [6:0] OP_ST  = 7'b0100000;
    localparam logic [6:0] OP_IOR = 7'b0010001;
    localparam logic [6:0] OP_IOW = 7'b0100001;
    localparam logic [6:0] OP_BRZ = 7'b1100000;
    localparam logic [6:0] OP_BRN = 7'b1100001;
    localparam logic [6:0] OP_JMP = 7'b1110000;
    localparam logic [6:0] OP_HAL = 7'b1110001;
    localparam logic [6:0] OP_XXL = 7'b1110010;

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_INF = 3'd1,
        S_EX0 = 3'd2,
        S_MEM = 3'd3,
        S_XL1 = 3'd4,
        S_HLT = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [XW-1:0]    r_xl_cnt;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [6:0]              w_op;
    logic [RA_W-1:0]         w_dst;
    logic [RA_W-1:0]         w_sa;
    logic [RA_W-1:0]         w_sb;
    logic [3*(RA_W+1)-1:0]   w_rs;
    logic                    w_is_alu;
    logic                    w_is_imm;
    logic                    w_is_ld;
    logic                    w_is_st;
    logic                    w_is_ior;
    logic                    w_is_iow;
    logic                    w_is_mem;
    logic                    w_is_brz;
    logic                    w_is_brn;
    logic                    w_is_jmp;
    logic                    w_is_hal;
    logic                    w_is_xxl;
    logic                    w_xl_exit;

    assign w_op     = ins_in[IW-1 -: 7];
    assign w_dst    = ins_in[3*RA_W-1 -: RA_W];
    assign w_sa     = ins_in[2*RA_W-1 -: RA_W];
    assign w_sb     = ins_in[RA_W-1:0];
    assign w_rs     = {1'b0, w_dst, 1'b0, w_sa, 1'b0, w_sb};

    assign w_is_alu = (w_op[6:4] == 3'b000);
    assign w_is_imm = (w_op == OP_LDI) || (w_op == OP_ADI);
    assign w_is_ld  = (w_op == OP_LD);
    assign w_is_st  = (w_op == OP_ST);
    assign w_is_ior = (w_op == OP_IOR);
    assign w_is_iow = (w_op == OP_IOW);
    assign w_is_mem = w_is_ld || w_is_st || w_is_ior || w_is_iow;
    assign w_is_brz = (w_op == OP_BRZ);
    assign w_is_brn = (w_op == OP_BRN);
    assign w_is_jmp = (w_op == OP_JMP);
    assign w_is_hal = (w_op == OP_HAL);
    assign w_is_xxl = (w_op == OP_XXL);

    // The loop ends on a zero flag or once the iteration budget is spent.
    assign w_xl_exit = z_in || (r_xl_cnt == XL_MAX_C);

    // ------------------------------------------------------------------
    // State register and XL iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RST;
            r_xl_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EX0 && w_is_xxl && !z_in) begin
                r_xl_cnt <= XW'(1);
            end else if (r_state == S_XL1 && !w_xl_exit) begin
                r_xl_cnt <= r_xl_cnt + XW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST: w_next = S_INF;
            S_INF: w_next = ins_vld ? S_EX0 : S_INF;
            S_EX0: begin
                if (w_is_mem)                 w_next = S_MEM;
                else if (w_is_hal)            w_next = S_HLT;
                else if (w_is_xxl && !z_in)   w_next = S_XL1;
                else                          w_next = S_INF;
            end
            S_MEM: w_next = dmem_rdy  ? S_INF : S_MEM;
            S_XL1: w_next = w_xl_exit ? S_INF : S_XL1;
            S_HLT: w_next = resume_in ? S_INF : S_HLT;
            default: w_next = S_RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        il_out     = 1'b0;
        ps_out     = 2'b00;
        rw_out     = 1'b0;
        rs_out     = '0;
        mm_out     = 1'b0;
        md_out     = 2'b00;
        mb_out     = 1'b0;
        fs_out     = 4'b0000;
        wen_out    = 1'b1;
        iom_out    = 1'b0;
        mreq_out   = 1'b0;
        halted_out = 1'b0;

        case (r_state)
            S_INF: begin
                il_out = ins_vld;
            end

            S_EX0: begin
                rs_out = w_rs;
                if (w_is_alu || w_is_imm) begin
                    rw_out = 1'b1;
                    fs_out = w_op[3:0];
                    mb_out = w_is_imm;
                    ps_out = 2'b01;
                end else if (w_is_mem) begin
                    ps_out = 2'b00;
                end else if (w_is_brz) begin
                    ps_out = z_in ? 2'b10 : 2'b01;
                end else if (w_is_brn) begin
                    ps_out = n_in ? 2'b10 : 2'b01;
                end else if (w_is_jmp) begin
                    ps_out = 2'b11;
                end else if (w_is_hal) begin
                    ps_out = 2'b00;
                end else if (w_is_xxl) begin
                    // First XXL pass: register selects forced to zero.
                    rs_out = '0;
                    mm_out = 1'b1;
                    fs_out = 4'b1110;
                    ps_out = z_in ? 2'b01 : 2'b00;
                end else begin
                    // Unknown opcode behaves as a NOP.
                    ps_out = 2'b01;
                end
            end

            S_MEM: begin
                // Everything except the completion strobes depends only on
                // the held instruction, so controls stay stable while waiting.
                mreq_out = 1'b1;
                rs_out   = w_rs;
                iom_out  = w_is_ior || w_is_iow;
                if (w_is_ld)  md_out = 2'b01;
                if (w_is_ior) md_out = 2'b10;
                wen_out  = !(w_is_st || w_is_iow);
                if (dmem_rdy) begin
                    rw_out = w_is_ld || w_is_ior;
                    ps_out = 2'b01;
                end
            end

            S_XL1: begin
                mm_out = 1'b1;
                fs_out = 4'b1110;
                ps_out = w_xl_exit ? 2'b01 : 2'b00;
            end

            S_HLT: begin
                halted_out = 1'b1;
                // Resume steps past the HAL instruction.
                ps_out     = resume_in ? 2'b01 : 2'b00;
            end

            default: ;
        endcase
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_cu_mc.sv
// ---------------------------------------------------------------------------
// tb_cu_mc : directed testbench for cu_mc with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cu_mc;

  localparam int IW = 16;

  localparam logic [2:0] ST_RST = 3'd0;
  localparam logic [2:0] ST_INF = 3'd1;
  localparam logic [2:0] ST_EX0 = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_XL1 = 3'd4;
  localparam logic [2:0] ST_HLT = 3'd5;

  localparam logic [6:0] OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_LDI = 7'b1001100;
  localparam logic [6:0] OP_LD  = 7'b0010000;
  localparam logic [6:0] OP_ST  = 7'b0100000;
  localparam logic [6:0] OP_IOR = 7'b0010001;
  localparam logic [6:0] OP_BRZ = 7'b1100000;
  localparam logic [6:0] OP_BRN = 7'b1100001;
  localparam logic [6:0] OP_JMP = 7'b1110000;
  localparam logic [6:0] OP_HAL = 7'b1110001;
  localparam logic [6:0] OP_XXL = 7'b1110010;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] ins_in    = '0;
  logic          ins_vld   = 1'b0;
  logic          dmem_rdy  = 1'b0;
  logic          z_in      = 1'b0;
  logic          n_in      = 1'b0;
  logic          resume_in = 1'b0;

  logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out, mreq_out, halted_out;
  logic [1:0]  ps_out, md_out;
  logic [11:0] rs_out;
  logic [3:0]  fs_out;
  logic [2:0]  state_out;

  cu_mc #(.IW(IW), .RA_W(3), .XL_MAX(255)) dut (
    .clk(clk), .rst(rst), .ins_in(ins_in), .ins_vld(ins_vld),
    .dmem_rdy(dmem_rdy), .z_in(z_in), .n_in(n_in), .resume_in(resume_in),
    .il_out(il_out), .ps_out(ps_out), .rw_out(rw_out), .rs_out(rs_out),
    .mm_out(mm_out), .md_out(md_out), .mb_out(mb_out), .fs_out(fs_out),
    .wen_out(wen_out), .iom_out(iom_out), .mreq_out(mreq_out),
    .halted_out(halted_out), .state_out(state_out)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [6:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b};
  endfunction

  // From INF, present an instruction and advance into EX0.
  task automatic fetch(input logic [IW-1:0] ins);
    ins_in  = ins;
    ins_vld = 1'b1;
    step();
    ins_vld = 1'b0;
  endtask

  // Reset-state output pattern: everything 0 except wen.
  function automatic logic [31:0] out_vec();
    return {8'd0, il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
            wen_out, iom_out, mreq_out, halted_out};
  endfunction

  int xl_cycles;
  int ps1_count;
  int halt_cycles;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // ---- 1: reset, then first fetch ----
    step();
    settle();
    check("rst_state", state_out, ST_RST);
    check("rst_outs", out_vec(), 32'h0000_0008);
    step();
    rst = 1'b0;
    ins_in  = mk(OP_ADD, 3'd1, 3'd2, 3'd3);
    ins_vld = 1'b1;
    settle();
    check("rst_state2", state_out, ST_RST);
    step();
    settle();
    check("inf_state", state_out, ST_INF);
    check("inf_il", il_out, 1);
    check("inf_ps", ps_out, 0);
    step();
    ins_vld = 1'b0;
    settle();

    // ---- 2: ADD r1,r2,r3 ----
    check("add_state", state_out, ST_EX0);
    check("add_rw", rw_out, 1);
    check("add_rs", rs_out, 12'h123);
    check("add_fs", fs_out, 4'b0010);
    check("add_ps", ps_out, 2'b01);
    check("add_mb", mb_out, 0);
    step();
    settle();
    check("add_back_inf", state_out, ST_INF);
    check("add_inf_rs0", rs_out, 0);

    // ins_vld low: PC held, resume/dmem_rdy ignored
    resume_in = 1'b1;
    dmem_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_ps", ps_out, 0);
      check("stall_il", il_out, 0);
      step();
    end
    resume_in = 1'b0;
    dmem_rdy  = 1'b0;
    settle();
    check("stall_state", state_out, ST_INF);

    // ---- LDI r6,#? : immediate ALU op ----
    fetch(mk(OP_LDI, 3'd6, 3'd0, 3'd5));
    settle();
    check("ldi_mb", mb_out, 1);
    check("ldi_fs", fs_out, 4'b1100);
    check("ldi_rw", rw_out, 1);
    check("ldi_ps", ps_out, 2'b01);
    step();

    // ---- 3: LD r4,r5 with dmem_rdy low for 3 cycles ----
    fetch(mk(OP_LD, 3'd4, 3'd5, 3'd0));
    settle();
    check("ld_ex0_state", state_out, ST_EX0);
    check("ld_ex0_ps", ps_out, 0);
    check("ld_ex0_rw", rw_out, 0);
    check("ld_ex0_mreq", mreq_out, 0);
    // expected {mreq, rw, ps, md} per MEM cycle
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, 2'b00, 2'b01});
    exp_q.push_back({1'b1, 1'b1, 2'b01, 2'b01});
    step();
    for (int i = 0; i < 4; i++) begin
      logic [5:0] e;
      dmem_rdy = (i == 3);
      settle();
      e = exp_q.pop_front();
      check("ld_mem_ctl", {26'd0, mreq_out, rw_out, ps_out, md_out}, {26'd0, e});
      check("ld_mem_wen", wen_out, 1);
      check("ld_mem_rs", rs_out, 12'h450);
      step();
    end
    dmem_rdy = 1'b0;
    settle();
    check("ld_back_inf", state_out, ST_INF);
    check("ld_inf_mreq", mreq_out, 0);

    // ---- 4: ST with ready in first MEM cycle ----
    fetch(mk(OP_ST, 3'd0, 3'd2, 3'd3));
    dmem_rdy = 1'b1;   // high in EX0 too: must be ignored there
    settle();
    check("st_ex0_ps", ps_out, 0);
    check("st_ex0_wen", wen_out, 1);
    step();
    settle();
    check("st_state", state_out, ST_MEM);
    check("st_wen", wen_out, 0);
    check("st_mreq", mreq_out, 1);
    check("st_rw", rw_out, 0);
    check("st_ps", ps_out, 2'b01);
    check("st_iom", iom_out, 0);
    step();
    dmem_rdy = 1'b0;
    settle();
    check("st_inf_mreq", mreq_out, 0);
    check("st_inf_wen", wen_out, 1);

    // ---- IOR ----
    fetch(mk(OP_IOR, 3'd7, 3'd1, 3'd0));
    step();
    settle();
    check("ior_iom", iom_out, 1);
    check("ior_md", md_out, 2'b10);
    check("ior_rw_wait", rw_out, 0);
    dmem_rdy = 1'b1;
    settle();
    check("ior_rw", rw_out, 1);
    check("ior_wen", wen_out, 1);
    step();
    dmem_rdy = 1'b0;

    // ---- branches and unknown opcode ----
    z_in = 1'b1;
    fetch(mk(OP_BRZ, 3'd0, 3'd0, 3'd0));
    settle();
    check("brz_taken", ps_out, 2'b10);
    check("brz_rw", rw_out, 0);
    step();
    z_in = 1'b0;
    n_in = 1'b0;
    fetch(mk(OP_BRN, 3'd0, 3'd0, 3'd0));
    settle();
    check("brn_not", ps_out, 2'b01);
    check("brn_fs", fs_out, 0);
    step();
    fetch(mk(OP_JMP, 3'd0, 3'd1, 3'd0));
    settle();
    check("jmp_ps", ps_out, 2'b11);
    step();
    fetch(mk(OP_BAD, 3'd1, 3'd1, 3'd1));
    settle();
    check("nop_ps", ps_out, 2'b01);
    check("nop_rw", rw_out, 0);
    check("nop_wen", wen_out, 1);
    step();
    settle();
    check("nop_inf", state_out, ST_INF);

    // ---- XXL with z set in EX0: immediate exit ----
    z_in = 1'b1;
    fetch(mk(OP_XXL, 3'd1, 3'd2, 3'd3));
    settle();
    check("xxlz_ps", ps_out, 2'b01);
    check("xxlz_rs", rs_out, 0);
    step();
    settle();
    check("xxlz_inf", state_out, ST_INF);
    z_in = 1'b0;

    // ---- 5: XXL with z low: 255 iterations ----
    fetch(mk(OP_XXL, 3'd1, 3'd2, 3'd3));
    settle();
    check("xxl_mm", mm_out, 1);
    check("xxl_fs", fs_out, 4'b1110);
    check("xxl_rs", rs_out, 0);
    check("xxl_ps", ps_out, 0);
    step();
    settle();
    check("xl1_mm", mm_out, 1);
    check("xl1_fs", fs_out, 4'b1110);
    xl_cycles = 0;
    ps1_count = 0;
    for (int i = 0; i < 300; i++) begin
      settle();
      if (state_out != ST_XL1) break;
      xl_cycles++;
      if (ps_out == 2'b01) ps1_count++;
      step();
    end
    check("xl1_cycles", xl_cycles, 255);
    check("xl1_ps01", ps1_count, 1);
    check("xl1_exit", state_out, ST_INF);

    // ---- 6: HAL, resume after 5 cycles ----
    fetch(mk(OP_HAL, 3'd0, 3'd0, 3'd0));
    settle();
    check("hal_ps", ps_out, 0);
    step();
    halt_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (halted_out === 1'b1 && ps_out == 2'b00) halt_cycles++;
      step();
    end
    check("hlt_cycles", halt_cycles, 5);
    resume_in = 1'b1;
    settle();
    check("hlt_resume_ps", ps_out, 2'b01);
    check("hlt_resume_h", halted_out, 1);
    step();
    resume_in = 1'b0;
    settle();
    check("hlt_to_inf", state_out, ST_INF);
    check("hlt_clr", halted_out, 0);

    // ---- reset in the middle of a store ----
    fetch(mk(OP_ST, 3'd0, 3'd4, 3'd5));
    step();
    settle();
    check("abort_mreq", mreq_out, 1);
    check("abort_wen", wen_out, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("abort_state", state_out, ST_RST);
    check("abort_outs", out_vec(), 32'h0000_0008);
    step();
    settle();
    check("abort_inf", state_out, ST_INF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
